// File: rtl/multi_watchdog_timer.sv
// multi_watchdog_timer
//   NUM_CH independent watchdog down-counters driven by one shared tick
//   prescaler. Each channel is a small IDLE/RUN/DONE state machine with a
//   programmable timeout, a kick (restart) strobe and one-shot or auto-reload
//   behaviour. An expiry raises a registered one-cycle pulse and a sticky flag
//   that stays set until an explicit clear.
//
// Ports
//   clk           clock, all state on the rising edge
//   arst_n        asynchronous active-low reset
//   enable        [NUM_CH]            per-channel run enable (level)
//   kick          [NUM_CH]            per-channel restart strobe
//   auto_reload   [NUM_CH]            1 = keep running after expiry
//   timeout       [NUM_CH*CNTR_BITS]  per-channel load value in ticks
//   clear         [NUM_CH]            sticky-flag clear strobe
//   expired       [NUM_CH]            sticky expiry flags (registered)
//   expire_pulse  [NUM_CH]            one-cycle expiry strobes (registered)
//   any_expired                       OR of the sticky flags
module multi_watchdog_timer #(
  parameter int NUM_CH    = 4,
  parameter int CNTR_BITS = 16,
  parameter int PRESCALE  = 1
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [NUM_CH-1:0]           enable,
  input  logic [NUM_CH-1:0]           kick,
  input  logic [NUM_CH-1:0]           auto_reload,
  input  logic [NUM_CH*CNTR_BITS-1:0] timeout,
  input  logic [NUM_CH-1:0]           clear,
  output logic [NUM_CH-1:0]           expired,
  output logic [NUM_CH-1:0]           expire_pulse,
  output logic                        any_expired
);

  // A one-bit prescaler is kept even when PRESCALE=1 so the width is never zero.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNTR_BITS-1:0] CNT_ZERO = {CNTR_BITS{1'b0}};
  localparam logic [CNTR_BITS-1:0] CNT_ONE  = CNTR_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [PRE_W-1:0]     pre_r;
  logic                 tick_s;

  state_t               state_r     [NUM_CH];
  state_t               state_nxt_s [NUM_CH];
  logic [CNTR_BITS-1:0] count_r     [NUM_CH];
  logic [CNTR_BITS-1:0] count_nxt_s [NUM_CH];
  logic [NUM_CH-1:0]    expired_r;
  logic [NUM_CH-1:0]    expired_nxt_s;
  logic [NUM_CH-1:0]    pulse_r;
  logic [NUM_CH-1:0]    pulse_nxt_s;

  // Shared free-running prescaler; never restarted by kick or enable, so a
  // fresh load is not phase-aligned to the next tick.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (pre_r == PRE_LAST) begin
      pre_r <= {PRE_W{1'b0}};
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  assign tick_s = (pre_r == PRE_LAST);

  // Per-channel next-state, next-count, pulse and sticky-flag logic.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt_s[i] = state_r[i];
      count_nxt_s[i] = count_r[i];
      pulse_nxt_s[i] = 1'b0;
      // Clear first; an expiry below re-sets the flag, so set wins.
      expired_nxt_s[i] = expired_r[i] & ~clear[i];

      case (state_r[i])
        ST_IDLE: begin
          if (enable[i]) begin
            count_nxt_s[i] = timeout[i*CNTR_BITS +: CNTR_BITS];
            state_nxt_s[i] = ST_RUN;
          end else begin
            count_nxt_s[i] = CNT_ZERO;
          end
        end
        ST_RUN: begin
          if (!enable[i]) begin
            count_nxt_s[i] = CNT_ZERO;
            state_nxt_s[i] = ST_IDLE;
          end else if (kick[i]) begin
            count_nxt_s[i] = timeout[i*CNTR_BITS +: CNTR_BITS];
          end else if (tick_s && (count_r[i] == CNT_ONE)) begin
            pulse_nxt_s[i]   = 1'b1;
            expired_nxt_s[i] = 1'b1;
            if (auto_reload[i]) begin
              count_nxt_s[i] = timeout[i*CNTR_BITS +: CNTR_BITS];
            end else begin
              count_nxt_s[i] = CNT_ZERO;
              state_nxt_s[i] = ST_DONE;
            end
          end else if (tick_s && (count_r[i] > CNT_ONE)) begin
            count_nxt_s[i] = count_r[i] - CNT_ONE;
          end else begin
            // No tick, or count==0 (timeout=0 parks the channel): hold.
            count_nxt_s[i] = count_r[i];
          end
        end
        ST_DONE: begin
          if (!enable[i]) begin
            state_nxt_s[i] = ST_IDLE;
          end else if (kick[i]) begin
            count_nxt_s[i] = timeout[i*CNTR_BITS +: CNTR_BITS];
            state_nxt_s[i] = ST_RUN;
          end else begin
            state_nxt_s[i] = ST_DONE;
          end
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
          count_nxt_s[i] = CNT_ZERO;
        end
      endcase
    end
  end

  // Channel state, counters, flags and pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= ST_IDLE;
        count_r[i] <= CNT_ZERO;
      end
      expired_r <= {NUM_CH{1'b0}};
      pulse_r   <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= state_nxt_s[i];
        count_r[i] <= count_nxt_s[i];
      end
      expired_r <= expired_nxt_s;
      pulse_r   <= pulse_nxt_s;
    end
  end

  assign expired      = expired_r;
  assign expire_pulse = pulse_r;
  assign any_expired  = |expired_r;

endmodule

// File: tb/tb_multi_watchdog_timer.sv
// Directed testbench for multi_watchdog_timer. Two instances share clock and
// reset: dut1 with PRESCALE=1 and dut4 with PRESCALE=4.
module tb_multi_watchdog_timer;

  logic        clk;
  logic        arst_n;
  logic [3:0]  en1, kick1, ar1, clr1, exp1, pls1;
  logic [63:0] tmo1;
  logic        any1;
  logic [3:0]  en4, kick4, ar4, clr4, exp4, pls4;
  logic [63:0] tmo4;
  logic        any4;

  int n_checks;
  int n_fail;
  int n;
  int npulse;

  multi_watchdog_timer #(.NUM_CH(4), .CNTR_BITS(16), .PRESCALE(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .enable(en1), .kick(kick1),
    .auto_reload(ar1), .timeout(tmo1), .clear(clr1),
    .expired(exp1), .expire_pulse(pls1), .any_expired(any1)
  );

  multi_watchdog_timer #(.NUM_CH(4), .CNTR_BITS(16), .PRESCALE(4)) dut4 (
    .clk(clk), .arst_n(arst_n), .enable(en4), .kick(kick4),
    .auto_reload(ar4), .timeout(tmo4), .clear(clr4),
    .expired(exp4), .expire_pulse(pls4), .any_expired(any4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance k rising edges; return 1 time unit after the last one.
  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst_n = 1'b0;
    en1 = 4'h0; kick1 = 4'h0; ar1 = 4'h0; clr1 = 4'h0; tmo1 = 64'h0;
    en4 = 4'h0; kick4 = 4'h0; ar4 = 4'h0; clr4 = 4'h0; tmo4 = 64'h0;

    // Reset state
    cyc(2);
    chk("rst_expired", {28'h0, exp1}, 32'h0);
    chk("rst_pulse", {28'h0, pls1}, 32'h0);
    chk("rst_any", {31'h0, any1}, 32'h0);
    chk("rst_expired4", {28'h0, exp4}, 32'h0);
    arst_n = 1'b1;
    cyc(1);

    // One-shot ch0, T=5: pulse after edge E+5
    tmo1[15:0] = 16'd5;
    en1[0] = 1'b1;
    cyc(1);                 // edge E
    cyc(4);                 // E+4
    chk("os_pulse_early", {31'h0, pls1[0]}, 32'h0);
    chk("os_exp_early", {31'h0, exp1[0]}, 32'h0);
    cyc(1);                 // E+5
    chk("os_pulse", {28'h0, pls1}, 32'h1);
    chk("os_expired", {28'h0, exp1}, 32'h1);
    chk("os_any", {31'h0, any1}, 32'h1);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      npulse += int'(pls1[0]);
    end
    chk("os_no_more_pulses", npulse, 32'd0);
    chk("os_sticky", {31'h0, exp1[0]}, 32'h1);
    en1[0] = 1'b0;
    clr1[0] = 1'b1;
    cyc(1);
    clr1[0] = 1'b0;
    chk("os_cleared", {28'h0, exp1}, 32'h0);

    // Kick ch1 every 4 clocks with T=5 for 50 clocks: no expiry
    tmo1[31:16] = 16'd5;
    en1[1] = 1'b1;
    cyc(1);                 // edge E
    npulse = 0;
    for (int i = 0; i < 50; i++) begin
      kick1[1] = (i % 4 == 3);
      cyc(1);
      npulse += int'(pls1[1]);
    end
    kick1[1] = 1'b0;
    en1[1] = 1'b0;
    cyc(1);
    chk("kick_no_pulse", npulse, 32'd0);
    chk("kick_no_flag", {31'h0, exp1[1]}, 32'h0);

    // Kick on the would-expire edge of ch2 (T=5): suppressed, reloads to 5
    tmo1[47:32] = 16'd5;
    en1[2] = 1'b1;
    cyc(1);                 // E
    cyc(4);                 // E+4, count==1
    kick1[2] = 1'b1;
    cyc(1);                 // E+5
    kick1[2] = 1'b0;
    chk("kick_edge_no_pulse", {31'h0, pls1[2]}, 32'h0);
    chk("kick_edge_no_flag", {31'h0, exp1[2]}, 32'h0);
    cyc(4);                 // E+9
    chk("kick_reload_early", {31'h0, pls1[2]}, 32'h0);
    cyc(1);                 // E+10
    chk("kick_reload_pulse", {31'h0, pls1[2]}, 32'h1);
    en1[2] = 1'b0;
    clr1[2] = 1'b1;
    cyc(1);
    clr1[2] = 1'b0;

    // Auto-reload on dut4 ch0, T=3, PRESCALE=4
    tmo4[15:0] = 16'd3;
    ar4[0] = 1'b1;
    en4[0] = 1'b1;
    cyc(1);                 // load edge
    n = 0;
    while (n < 40) begin
      cyc(1);
      n++;
      if (pls4[0]) break;
    end
    chk("ar_first_in_window", {31'h0, (n >= 9 && n <= 12)}, 32'h1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (n < 40) begin
        cyc(1);
        n++;
        if (pls4[0]) break;
      end
      chk("ar_period", n, 32'd12);
    end
    en4[0] = 1'b0;
    ar4[0] = 1'b0;
    clr4[0] = 1'b1;
    cyc(1);
    clr4[0] = 1'b0;
    chk("ar_cleared", {28'h0, exp4}, 32'h0);

    // Expiry and clear on the same edge (ch3, T=3): set wins
    tmo1[63:48] = 16'd3;
    en1[3] = 1'b1;
    cyc(1);                 // E
    cyc(2);                 // E+2
    chk("sc_pre_any", {31'h0, any1}, 32'h0);
    clr1[3] = 1'b1;
    cyc(1);                 // E+3: expiry + clear
    chk("sc_pulse", {28'h0, pls1}, 32'h8);
    chk("sc_set_wins", {28'h0, exp1}, 32'h8);
    cyc(1);                 // clear alone
    clr1[3] = 1'b0;
    chk("sc_clear_alone", {28'h0, exp1}, 32'h0);
    chk("sc_any_low", {31'h0, any1}, 32'h0);
    en1[3] = 1'b0;
    cyc(1);

    // Concurrent channels: ch0 T=2, ch3 T=7, ch1 T=4 dropped mid-count
    tmo1[15:0]  = 16'd2;
    tmo1[31:16] = 16'd4;
    tmo1[63:48] = 16'd7;
    en1 = 4'b1011;
    cyc(1);                 // E
    for (int c = 1; c <= 12; c++) begin
      cyc(1);               // E+c
      chk($sformatf("conc_pulse_c%0d", c), {28'h0, pls1},
          (c == 2) ? 32'h1 : ((c == 7) ? 32'h8 : 32'h0));
      if (c == 2) en1[1] = 1'b0;
    end
    chk("conc_flags", {28'h0, exp1}, 32'h9);

    // Asynchronous reset mid-count with flags set
    tmo1[47:32] = 16'd6;
    en1 = 4'b0100;
    cyc(2);
    arst_n = 1'b0;
    #1;
    chk("arst_expired", {28'h0, exp1}, 32'h0);
    chk("arst_any", {31'h0, any1}, 32'h0);
    chk("arst_pulse", {28'h0, pls1}, 32'h0);
    #1;
    arst_n = 1'b1;
    cyc(1);                 // E: re-arm load with enable held
    cyc(5);                 // E+5
    chk("rearm_early", {28'h0, pls1}, 32'h0);
    cyc(1);                 // E+6
    chk("rearm_pulse", {28'h0, pls1}, 32'h4);
    chk("rearm_flag", {28'h0, exp1}, 32'h4);

    // timeout=0 while running never expires
    tmo1[31:16] = 16'd0;
    en1 = 4'b0110;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      npulse += int'(pls1[1]);
    end
    chk("t0_no_pulse", npulse, 32'd0);
    chk("t0_no_flag", {31'h0, exp1[1]}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_watchdog_timer.md
# multi_watchdog_timer

Multi-channel, parametrised watchdog: NUM_CH independent down-counters share one clock prescaler. Each channel has a runtime-programmable timeout, a kick (restart) input, and one-shot or auto-reload mode. Expiry produces a one-cycle pulse and a sticky flag with explicit clear. The block sits beside link/lane bring-up logic and supervises per-lane handshakes that can stall: alignment, lock and credit return.

## Interface
- NUM_CH, 4, number of independent watchdog channels (>=1)
- CNTR_BITS, 16, per-channel count width; max timeout 2^CNTR_BITS-1 ticks
- PRESCALE, 1, clocks per tick (>=1); 1 means every clock is a tick

- clk  in  1  sole clock; all state is on its rising edge
- arst_n  in  1  asynchronous, active-low reset; all registers clear immediately
- enable  in  NUM_CH  per-channel run enable, level
- kick  in  NUM_CH  per-channel restart, one-cycle strobe
- auto_reload  in  NUM_CH  1 = reload and keep running after expiry; 0 = one-shot
- timeout  in  NUM_CH*CNTR_BITS  per-channel load value in ticks; channel i uses bits [i*CNTR_BITS +: CNTR_BITS]
- clear  in  NUM_CH  clears the sticky expired flag, strobe
- expired  out  NUM_CH  sticky expiry flag
- expire_pulse  out  NUM_CH  one-cycle strobe on each expiry event
- any_expired  out  1  OR of expired (combinational from flags)

## Operation
- Prescaler:
  - Free-running counter over 0..PRESCALE-1; reset value 0.
  - tick = (pre == PRESCALE-1); with PRESCALE=1, tick is constantly 1.
  - The prescaler is shared by all channels and is never restarted by kick or enable.
- Each channel has a state machine with states IDLE, RUN and DONE; reset state is IDLE, count 0.
- IDLE:
  - When enable=1: load count=timeout and go to RUN.
  - When enable=0: stay in IDLE.
- RUN, priority order (highest first):
  - enable=0: go to IDLE, count=0.
  - kick: count=timeout, stay in RUN.
  - tick with count==1 (expiry event): pulse and set the flag. If auto_reload, count=timeout and stay in RUN; otherwise count=0 and go to DONE.
  - tick with count>1: count-1.
  - count==0 never expires (timeout=0 disables the channel while it is in RUN).
- DONE:
  - enable=0: go to IDLE.
  - kick: count=timeout, go to RUN.
  - Ticks are ignored.
- kick is ignored while enable=0.
- timeout is sampled only on a load (enable rise, kick, or auto-reload); changing it mid-count has no effect until the next load.
- Sticky flag:
  - Set by an expiry event; cleared by clear.
  - An expiry event and clear on the same cycle leave the flag at 1 (set wins).
  - Disabling a channel does not clear its flag.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-operation: the prescaler, every count and every flag go to 0 and every state goes to IDLE, asynchronously. Deassertion is assumed synchronised upstream.

## Timing
- Reset values: expired=0, expire_pulse=0, any_expired=0.
- With PRESCALE=1, enable first sampled high at edge E and no kicks:
  - expire_pulse is high during the cycle after edge E+T, where T=timeout.
  - expired is high from the same edge.
- With PRESCALE>1: the first expiry falls between (T-1)*PRESCALE+1 and T*PRESCALE clocks after load, because the phase of the shared prescaler is not aligned to the load.
- Auto-reload period is exactly T*PRESCALE clocks between expire_pulse strobes.
- A kick on the edge that would have expired suppresses that expiry (kick outranks tick).
- expire_pulse is registered and is never high on two consecutive cycles unless T=1 and PRESCALE=1 in auto-reload mode.
- any_expired follows expired with zero added latency.

## Test plan
- PRESCALE=1, T=5, one-shot, enable held from edge 0 -> expire_pulse high one cycle after edge 5; expired stays 1; no further pulses.
- Kick every 4 clocks with T=5 for 50 clocks -> no expiry. Kick coincident with the count==1 tick -> no pulse, count reloads to 5.
- auto_reload=1, T=3, PRESCALE=4 -> pulses exactly 12 clocks apart; first pulse within 9..12 clocks of enable.
- Expiry and clear on the same cycle -> expired=1. Clear alone next cycle -> expired=0, any_expired=0.
- Channel 0 T=2 and channel 3 T=7 run concurrently, with enable dropped on channel 1 mid-count -> correct independent pulses; channel 1 returns to IDLE and does not expire.
- arst_n asserted mid-count with expired=1 -> all outputs 0 immediately. After release, enable re-arm gives a full T-tick timeout. timeout=0 in RUN -> never expires.
